b2bd_converter: RTL and testbench

B2BD_CONVERTER -- requirements
Module: b2bd

---
 rtl/b2bd_converter.sv | 111 +++++++++++
 tb/tb_b2bd_converter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/b2bd_converter.sv
//------------------------------------------------------------------------------
// b2bd_converter
//
// Purpose:
//   Registered binary-to-BCD converter. The unsigned binary input is
//   converted combinationally with the shift-and-add-3 (double dabble)
//   method. The packed BCD result is captured in a single output register
//   on every rising clock edge, so the latency is exactly one cycle. There
//   is no handshake: every cycle carries a valid conversion.
//
// Parameters:
//   IN_W   - width of the binary input in bits (default 4)
//   DIGITS - number of BCD output digits (default 2); must satisfy
//            10^DIGITS > 2^IN_W - 1 so that every input value fits
//
// Ports:
//   clk - single clock; all state updates happen on its rising edge
//   rst - synchronous, active-high reset; clears led and takes priority
//         over conversion
//   sw  - [IN_W-1:0] unsigned binary value to convert
//   led - [4*DIGITS-1:0] packed BCD result; bits [3:0] hold the units
//         digit, [7:4] the tens digit, and so on. Unused upper digits
//         read as zero.
//------------------------------------------------------------------------------
module b2bd_converter #(
   parameter int IN_W   = 4,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       sw,
   output logic [4*DIGITS-1:0]   led
);

   //---------------------------------------------------------------------------
   // Elaboration-time range check
   //---------------------------------------------------------------------------
   // Largest representable decimal value plus one, saturating at the 64-bit
   // ceiling so that very large DIGITS values cannot wrap around.
   function automatic logic [63:0] pow10_sat(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int k = 0; k < n; k++) begin
         if (r > (64'hFFFF_FFFF_FFFF_FFFF / 64'd10)) begin
            r = 64'hFFFF_FFFF_FFFF_FFFF;
         end else begin
            r = r * 64'd10;
         end
      end
      return r;
   endfunction

   localparam logic [63:0] MAX_IN     = (64'd1 << IN_W) - 64'd1;
   localparam logic [63:0] DEC_RANGE  = pow10_sat(DIGITS);

   generate
      if (IN_W < 1 || IN_W > 63) begin : g_bad_in_w
         $error("b2bd_converter: IN_W must be in 1..63");
      end
      if (DIGITS < 1) begin : g_bad_digits
         $error("b2bd_converter: DIGITS must be at least 1");
      end
      if (!(DEC_RANGE > MAX_IN)) begin : g_bad_range
         $error("b2bd_converter: 10^DIGITS must exceed 2^IN_W - 1");
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Combinational double dabble
   //---------------------------------------------------------------------------
   // The working vector is {bcd digits, binary}. Before each of the IN_W left
   // shifts every digit that is 5 or more gets 3 added, so that the shift
   // carries it correctly into the next decimal place. After IN_W shifts the
   // binary part has been fully consumed and the digits hold the result.
   // Bits shifted out of the top are always zero because the range check
   // above guarantees the result fits in DIGITS digits.
   localparam int BCD_W = 4 * DIGITS;
   localparam int SH_W  = BCD_W + IN_W;

   logic [SH_W-1:0]  w_shift;
   logic [BCD_W-1:0] w_bcd;

   always_comb begin
      w_shift = {{BCD_W{1'b0}}, sw};
      for (int s = 0; s < IN_W; s++) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (w_shift[IN_W + 4*d +: 4] >= 4'd5) begin
               w_shift[IN_W + 4*d +: 4] = w_shift[IN_W + 4*d +: 4] + 4'd3;
            end
         end
         w_shift = w_shift << 1;
      end
      w_bcd = w_shift[SH_W-1 -: BCD_W];
   end

   //---------------------------------------------------------------------------
   // Output register: the only state in the block
   //---------------------------------------------------------------------------
   logic [BCD_W-1:0] r_led;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_led <= '0;
      end else begin
         r_led <= w_bcd;
      end
   end

   assign led = r_led;

endmodule

// File: tb/tb_b2bd_converter.sv
module tb_b2bd_converter;

   //---------------------------------------------------------------------------
   // Clock / reset / DUTs
   //---------------------------------------------------------------------------
   logic        clk;
   logic        rst;
   logic [3:0]  sw;
   logic [7:0]  led;
   logic [7:0]  sw_w;
   logic [11:0] led_w;

   int n_cmp;
   int n_err;

   logic [7:0]  exp_q[$];
   logic [11:0] exp_w_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   b2bd_converter #(.IN_W(4), .DIGITS(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw),
      .led (led)
   );

   b2bd_converter #(.IN_W(8), .DIGITS(3)) u_dut_w (
      .clk (clk),
      .rst (rst),
      .sw  (sw_w),
      .led (led_w)
   );

   //---------------------------------------------------------------------------
   // Reference model: decimal digits by repeated division
   //---------------------------------------------------------------------------
   function automatic logic [31:0] bcd_model(input int unsigned v, input int digits);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < digits; i++) begin
         r = r | ((32'(x % 10)) << (4*i));
         x = x / 10;
      end
      return r;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   //---------------------------------------------------------------------------
   // Tests
   //---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      sw  = 4'hF;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_cmp++;
         if (led !== 8'h00) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: got %h want 00", k, led);
         end
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (led !== 8'h15) begin
         n_err++;
         $display("FAIL reset_release: got %h want 15", led);
      end
   endtask

   task automatic test_sweep_low();
      for (int v = 0; v <= 9; v++) begin
         sw = 4'(v);
         tick();
         n_cmp++;
         if (led !== 8'(bcd_model(v, 2))) begin
            n_err++;
            $display("FAIL sweep_low[%0d]: got %h want %h", v, led, 8'(bcd_model(v, 2)));
         end
      end
   endtask

   task automatic test_sweep_high();
      for (int v = 10; v <= 15; v++) begin
         sw = 4'(v);
         tick();
         n_cmp++;
         if (led !== 8'(bcd_model(v, 2))) begin
            n_err++;
            $display("FAIL sweep_high[%0d]: got %h want %h", v, led, 8'(bcd_model(v, 2)));
         end
      end
   endtask

   task automatic test_glitch();
      sw = 4'd7;
      tick();
      n_cmp++;
      if (led !== 8'h07) begin
         n_err++;
         $display("FAIL glitch_pre: got %h want 07", led);
      end
      sw = 4'd12;
      #2;
      n_cmp++;
      if (led !== 8'h07) begin
         n_err++;
         $display("FAIL glitch_mid12: got %h want 07", led);
      end
      sw = 4'd3;
      #2;
      n_cmp++;
      if (led !== 8'h07) begin
         n_err++;
         $display("FAIL glitch_mid3: got %h want 07", led);
      end
      tick();
      n_cmp++;
      if (led !== 8'h03) begin
         n_err++;
         $display("FAIL glitch_post: got %h want 03", led);
      end
   endtask

   task automatic test_reset_pulse();
      logic [7:0] exp_seq [3];
      exp_seq[0] = 8'h09;
      exp_seq[1] = 8'h00;
      exp_seq[2] = 8'h09;
      sw  = 4'h9;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rst = (k == 1);
         tick();
         n_cmp++;
         if (led !== exp_seq[k]) begin
            n_err++;
            $display("FAIL reset_pulse[%0d]: got %h want %h", k, led, exp_seq[k]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] e;
      for (int k = 0; k < 200; k++) begin
         sw  = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 9) == 0);
         exp_q.push_back(rst ? 8'h00 : 8'(bcd_model(int'(sw), 2)));
         tick();
         e = exp_q.pop_front();
         n_cmp++;
         if (led !== e) begin
            n_err++;
            $display("FAIL random[%0d]: sw=%0d rst=%0b got %h want %h", k, sw, rst, led, e);
         end
         // mid-cycle input noise must not reach the register
         sw = 4'($urandom_range(0, 15));
         #2;
         n_cmp++;
         if (led !== e) begin
            n_err++;
            $display("FAIL random_hold[%0d]: got %h want %h", k, led, e);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_wide();
      int unsigned dir_v [3];
      logic [11:0] dir_e [3];
      logic [11:0] e;
      dir_v[0] = 255; dir_e[0] = 12'h255;
      dir_v[1] = 100; dir_e[1] = 12'h100;
      dir_v[2] = 0;   dir_e[2] = 12'h000;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sw_w = 8'(dir_v[k]);
         tick();
         n_cmp++;
         if (led_w !== dir_e[k]) begin
            n_err++;
            $display("FAIL wide_dir[%0d]: got %h want %h", dir_v[k], led_w, dir_e[k]);
         end
      end
      sw_w = 8'd199;
      rst  = 1'b1;
      tick();
      n_cmp++;
      if (led_w !== 12'h000) begin
         n_err++;
         $display("FAIL wide_reset: got %h want 000", led_w);
      end
      rst = 1'b0;
      for (int k = 0; k < 100; k++) begin
         sw_w = 8'($urandom_range(0, 255));
         exp_w_q.push_back(12'(bcd_model(int'(sw_w), 3)));
         tick();
         e = exp_w_q.pop_front();
         n_cmp++;
         if (led_w !== e) begin
            n_err++;
            $display("FAIL wide_random[%0d]: sw=%0d got %h want %h", k, sw_w, led_w, e);
         end
      end
   endtask

   //---------------------------------------------------------------------------
   // Sequence and report
   //---------------------------------------------------------------------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      sw    = 4'h0;
      sw_w  = 8'h00;
      @(negedge clk);
      test_reset();
      test_sweep_low();
      test_sweep_high();
      test_glitch();
      test_reset_pulse();
      test_random();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
